// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 decrypt core.
// Build option: AES_DEC_KEY_CACHE_EN (used by aes_dec_key_sched).
package aes_dec_pkg;

  typedef enum logic [2:0] {IDLE, KEXP, ADDK, ROUND, DONE} state_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Byte i of the block lives at [127-8i -: 8]; byte index = row + 4*col.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r)&3)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   m9 [4];
    logic [7:0]   mb [4];
    logic [7:0]   md [4];
    logic [7:0]   me [4];
    logic [7:0]   x2, x4, x8;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]  = s[127-8*(4*c+r) -: 8];
        x2    = gf_mul2(a[r]);
        x4    = gf_mul2(x2);
        x8    = gf_mul2(x4);
        m9[r] = x8 ^ a[r];
        mb[r] = x8 ^ x2 ^ a[r];
        md[r] = x8 ^ x4 ^ a[r];
        me[r] = x8 ^ x4 ^ x2;
      end
      o[127-32*c -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      o[119-32*c -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      o[111-32*c -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      o[103-32*c -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_dec_key_sched.sv
// Round-key register stepping forward (rk0 -> rk10) or backward (rk10 -> rk0) one key per clock.
// With AES_DEC_KEY_CACHE_EN defined, remembers the last key and its rk10 to skip forward expansion.
module aes_dec_key_sched
  import aes_dec_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [127:0] load_key_i,
  input  logic         fwd_i,
  input  logic         rev_i,
  input  logic [3:0]   rnd_i,
  output logic [127:0] key_o,
  output logic         hit_o
);

  logic [127:0] key_q;
  logic [127:0] key_fwd, key_rev, load_val;
  logic [7:0]   rcon;

  function automatic logic [127:0] fwd_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one expansion step: recover the previous round key from the current one.
  function automatic logic [127:0] rev_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0]  ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  assign rcon    = (rnd_i >= 4'd1 && rnd_i <= 4'd10) ? RCON[rnd_i] : 8'h00;
  assign key_fwd = fwd_expand(key_q, rcon);
  assign key_rev = rev_expand(key_q, rcon);
  assign key_o   = key_q;

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] ckey_q, crk10_q;
  logic         cvalid_q;

  assign hit_o    = cvalid_q && (load_key_i == ckey_q);
  assign load_val = hit_o ? crk10_q : load_key_i;

  // The key is captured at accept; the entry only becomes valid once rk10 is known.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ckey_q   <= '0;
      crk10_q  <= '0;
      cvalid_q <= 1'b0;
    end else if (load_i && !hit_o) begin
      ckey_q   <= load_key_i;
      cvalid_q <= 1'b0;
    end else if (fwd_i && rnd_i == 4'd10) begin
      crk10_q  <= key_fwd;
      cvalid_q <= 1'b1;
    end
  end
`else
  assign hit_o    = 1'b0;
  assign load_val = load_key_i;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      key_q <= '0;
    else if (load_i) key_q <= load_val;
    else if (fwd_i)  key_q <= key_fwd;
    else if (rev_i)  key_q <= key_rev;
  end

endmodule

// File: rtl/aes_128_decrypt_iter.sv
// Iterative AES-128 decryption: one inverse round per clock, valid/ready on both sides.
// Build option: AES_DEC_KEY_CACHE_EN enables the rk10 key cache in aes_dec_key_sched.
module aes_128_decrypt_iter
  import aes_dec_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_in,
  output logic         in_ready,
  input  logic [127:0] cipher_text_128,
  input  logic [127:0] cipher_key_128,
  output logic         valid_out,
  input  logic         out_ready,
  output logic [127:0] plan_text_128
);

  if (NR != 10) begin : g_bad_nr
    $error("aes_128_decrypt_iter supports only NR == 10");
  end

  localparam logic [3:0] LAST_RND = 4'(NR);

  state_t       fsm_q;
  logic [3:0]   rnd_q;
  logic [127:0] blk_q, pt_q;
  logic         in_ready_q, valid_out_q;
  logic [127:0] rk, t;
  logic         accept, cache_hit, key_fwd, key_rev;

  assign accept  = valid_in && in_ready_q;
  assign key_fwd = (fsm_q == KEXP);
  assign key_rev = (fsm_q == ADDK) || (fsm_q == ROUND && rnd_q != 4'd0);

  aes_dec_key_sched u_key_sched (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept),
    .load_key_i (cipher_key_128),
    .fwd_i      (key_fwd),
    .rev_i      (key_rev),
    .rnd_i      (rnd_q),
    .key_o      (rk),
    .hit_o      (cache_hit)
  );

  assign t = inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q       <= IDLE;
      rnd_q       <= 4'd0;
      blk_q       <= '0;
      pt_q        <= '0;
      in_ready_q  <= 1'b1;
      valid_out_q <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: if (accept) begin
          blk_q      <= cipher_text_128;
          in_ready_q <= 1'b0;
          if (cache_hit) begin
            rnd_q <= LAST_RND;
            fsm_q <= ADDK;
          end else begin
            rnd_q <= 4'd1;
            fsm_q <= KEXP;
          end
        end
        // rnd_q stays at the last round so ADDK steps back with the final rcon.
        KEXP: if (rnd_q == LAST_RND) fsm_q <= ADDK;
              else                   rnd_q <= rnd_q + 4'd1;
        ADDK: begin
          blk_q <= blk_q ^ rk;
          rnd_q <= LAST_RND - 4'd1;
          fsm_q <= ROUND;
        end
        ROUND: if (rnd_q == 4'd0) begin
          blk_q       <= t;
          pt_q        <= t;
          valid_out_q <= 1'b1;
          fsm_q       <= DONE;
        end else begin
          blk_q <= inv_mix_columns(t);
          rnd_q <= rnd_q - 4'd1;
        end
        DONE: if (out_ready) begin
          valid_out_q <= 1'b0;
          in_ready_q  <= 1'b1;
          fsm_q       <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign valid_out     = valid_out_q;
  assign plan_text_128 = pt_q;

endmodule

// File: tb/tb_aes_128_decrypt_iter.sv
// Directed-vector bench for aes_128_decrypt_iter (builds with or without AES_DEC_KEY_CACHE_EN).
module tb_aes_128_decrypt_iter;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         valid_in = 1'b0;
  logic         in_ready;
  logic [127:0] cipher_text_128 = '0;
  logic [127:0] cipher_key_128 = '0;
  logic         valid_out;
  logic         out_ready = 1'b0;
  logic [127:0] plan_text_128;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  aes_128_decrypt_iter #(.NR(10)) dut (
    .clk             (clk),
    .reset           (reset),
    .valid_in        (valid_in),
    .in_ready        (in_ready),
    .cipher_text_128 (cipher_text_128),
    .cipher_key_128  (cipher_key_128),
    .valid_out       (valid_out),
    .out_ready       (out_ready),
    .plan_text_128   (plan_text_128)
  );

  typedef struct {
    string        name;
    logic [127:0] ct;
    logic [127:0] key;
    logic [127:0] pt;
  } vec_t;

  vec_t vecs [4];

  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_AB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C_AB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P_AB = 128'h3243f6a8885a308d313198a2e0370734;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Returns just after the accepting edge.
  task automatic start_job(input logic [127:0] ct, input logic [127:0] key);
    @(negedge clk);
    cipher_text_128 = ct;
    cipher_key_128  = key;
    valid_in        = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  task automatic wait_done(input int start, output int lat);
    lat = start;
    while (valid_out !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int lat;
    int rises;
    int exp_lat2;
    logic [127:0] held;

    vecs[0] = '{"fips_c1",   C_C1, K_C1, P_C1};
    vecs[1] = '{"fips_appb", C_AB, K_AB, P_AB};
    vecs[2] = '{"zero_key",  128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 128'h0};
    vecs[3] = '{"sp800_ecb", 128'h3ad77bb40d7a3660a89ecaf32466ef97, K_AB,
                128'h6bc1bee22e409f96e93d7e117393172a};

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {127'h0, in_ready},  128'h1);
    check("rst_valid_out", {127'h0, valid_out}, 128'h0);
    check("rst_pt",        plan_text_128,       128'h0);
    @(negedge clk);
    reset = 1'b1;

    // Consecutive keys differ, so every job takes the full expansion path.
    for (int i = 0; i < 4; i++) begin
      start_job(vecs[i].ct, vecs[i].key);
      wait_done(0, lat);
      check({vecs[i].name, "_pt"},  plan_text_128,  vecs[i].pt);
      check({vecs[i].name, "_lat"}, 128'(lat),      128'd21);
      release_out();
    end

    // Backpressure: result held while downstream stalls.
    start_job(C_C1, K_C1);
    wait_done(0, lat);
    check("bp_lat", 128'(lat), 128'd21);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("bp_hold", {valid_out, in_ready, plan_text_128}, {1'b1, 1'b0, P_C1});
    end
    release_out();
    check("bp_release", {valid_out, in_ready, plan_text_128}, {1'b0, 1'b1, P_C1});

    // Busy drop: a second request at cycle 5 must be ignored.
    start_job(C_AB, K_AB);
    repeat (4) @(posedge clk);
    @(negedge clk);
    cipher_text_128 = C_C1;
    cipher_key_128  = K_C1;
    valid_in        = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    wait_done(5, lat);
    check("busy_pt",  plan_text_128, P_AB);
    check("busy_lat", 128'(lat),     128'd21);
    release_out();
    rises = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1 if (valid_out) rises++;
    end
    check("busy_no_second", 128'(rises), 128'd0);
    check("busy_idle_ready", {127'h0, in_ready}, 128'h1);

    // Asynchronous reset in the middle of a job.
    start_job(C_C1, K_C1);
    repeat (11) @(posedge clk);
    #2 reset = 1'b0;
    #1 check("midrst_outs", {valid_out, in_ready, plan_text_128}, {1'b0, 1'b1, 128'h0});
    @(negedge clk);
    reset = 1'b1;
    start_job(C_C1, K_C1);
    wait_done(0, lat);
    check("postrst_pt",  plan_text_128, P_C1);
    check("postrst_lat", 128'(lat),     128'd21);
    release_out();

    // Repeated key: shortened latency only when the key cache is built in.
    do_reset();
`ifdef AES_DEC_KEY_CACHE_EN
    exp_lat2 = 11;
`else
    exp_lat2 = 21;
`endif
    start_job(C_C1, K_C1);
    wait_done(0, lat);
    check("cache1_pt",  plan_text_128, P_C1);
    check("cache1_lat", 128'(lat),     128'd21);
    release_out();
    start_job(C_C1, K_C1);
    wait_done(0, lat);
    check("cache2_pt",  plan_text_128, P_C1);
    check("cache2_lat", 128'(lat),     128'(exp_lat2));
    release_out();
    start_job(C_AB, K_AB);
    wait_done(0, lat);
    check("cache3_pt",  plan_text_128, P_AB);
    check("cache3_lat", 128'(lat),     128'd21);
    release_out();
    held = plan_text_128;
    check("done_retains_pt", held, P_AB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
